iecdrv_track_stream: RTL and testbench
======================================

Name: iecdrv_track_stream

Overview:
- Head-side streamer for the byte-wide track buffer. It emulates the drive head's bit port on top of a byte port that uses the iecdrv_mem timing.
- While the motor runs, it reads track bytes and shifts them out MSB first as a serial bit stream, one bit per programmable bit cell.
- In write mode it replaces the streamed bits with incoming bits and writes each assembled byte back to the buffer.
- It also flags GCR sync (10 or more consecutive 1s) to the drive logic.

Parameters:
- ADDRWIDTH, 13: track buffer byte address width.
- DIVWIDTH, 8: width of the bit-cell divider.
- SYNC_LEN, 10: number of consecutive read 1-bits that asserts sync.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  drive clock enable; the bit timer counts only on ce.
- mtr  in  1  motor on. When low, the timer and bit position are frozen.
- wr_mode  in  1  1 = write head active. Sampled at each bit strobe.
- bit_div  in  DIVWIDTH  bit cell length = bit_div+1 ce pulses.
- track_len  in  ADDRWIDTH  track length in bytes; 0 means 2^ADDRWIDTH.
- din  in  1  bit to write. Sampled at the bit strobe when wr_mode=1.
- dout  out  1  current head bit.
- bit_strobe  out  1  one-clk pulse at each bit-cell boundary.
- sync  out  1  SYNC_LEN or more consecutive read 1-bits.
- byte_pos  out  ADDRWIDTH  byte index under the head.
- mem_addr  out  ADDRWIDTH  buffer address.
- mem_wdata  out  8  write data.
- mem_wren  out  1  one-clk write pulse.
- mem_q  in  8  read data, valid 2 clk after mem_addr is presented.

Behaviour:
- Reset values: dout=0, bit_strobe=0, sync=0, byte_pos=0, mem_addr=0, mem_wdata=0, mem_wren=0. Internal: bit counter=0, dirty=0, timer=0, state=FETCH.
- Reset mid-write drops the pending byte; mem_wren stays 0.
- State machine:
  - FETCH: drive mem_addr=byte_pos. Go to WAIT1.
  - WAIT1: go to WAIT2.
  - WAIT2: load shift register from mem_q, clear dirty, go to SHIFT.
  - SHIFT: run bit cells (see below). After the strobe for bit 7: if dirty, go to WRITE, else go to ADVANCE.
  - WRITE: mem_wren=1, mem_wdata=shift register, mem_addr=byte_pos for exactly one clk. Go to ADVANCE.
  - ADVANCE: byte_pos = byte_pos+1, or 0 when byte_pos+1 ≥ effective track_len. Go to FETCH.
- Byte turnaround is at most 5 clk.
  - The timer keeps running through it.
  - bit_div must give ≥6 clk per bit cell; otherwise behaviour is undefined.
- Bit timer:
  - Counts ce pulses only while mtr=1.
  - On reaching bit_div it reloads 0 and fires bit_strobe. Strobes occur only in SHIFT.
- At each strobe:
  - Read mode: dout = shift register[7]; shift left, refilling bit 0 with the old bit 7.
  - Write mode: dout = din; shift left with din entering at bit 0; set dirty.
  - Increment the bit counter (0..7, wrapping).
  - After 8 strobes the register holds the byte to write back in its original bit order.
- Mixed read/write bits within one byte are permitted: the byte is written back if any bit was written.
- Sync:
  - Counter saturates at SYNC_LEN.
  - Incremented on each read-mode strobe with dout=1; cleared on a read 0 or on any write-mode strobe.
  - sync = (count ≥ SYNC_LEN); it updates in the same cycle as dout.
- mtr low:
  - No strobes; dout, sync and bit position hold.
  - An in-flight FETCH/WAIT/WRITE/ADVANCE completes.
  - Streaming resumes at the same bit when mtr returns high.
- track_len shrunk below byte_pos: the next ADVANCE wraps to 0.
- track_len=1: every byte transition re-reads address 0. A write followed by FETCH returns the new data, since the memory registers the write before the read.
- bit_div changes take effect at the next timer reload.

Decomposition:
- Package iecdrv_track_pkg: state enum (FETCH, WAIT1, WAIT2, SHIFT, WRITE, ADVANCE) and the default SYNC_LEN constant.
- One sub-module, iecdrv_bit_timer: ce/mtr-gated divider with bit_div reload, producing the strobe.

Test Plan:
- Track bytes 0xA5,0x3C, track_len=2, bit_div=7, ce=1, mtr=1, read mode -> dout sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, then repeats; strobes every 8 clk; byte_pos cycles 0,1,0.
- Read bytes 0xFF,0xC0 -> sync rises on the 10th consecutive 1 (bit 1 of byte 1) and falls at the next 0.
- wr_mode=1 for one full byte at byte_pos 3 with din pattern 0x52 -> exactly one mem_wren at addr 3 with mem_wdata=0x52; the next revolution reads 0x52.
- Write bits 0..3 only (din=1) over 0x00, then read mode -> write-back value 0xF0; sync cleared during the write bits.
- mtr dropped after bit 4 for 100 clk -> no strobes; resume yields bit 5 of the same byte; byte_pos unchanged.
- Async reset asserted in WRITE state -> mem_wren=0 immediately; all outputs at reset values; after release the first fetch is at addr 0.

Source files
------------

// File: rtl/iecdrv_track_pkg.sv
// Shared types and defaults for the track-buffer head streamer.
package iecdrv_track_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StWait1,
        StWait2,
        StShift,
        StWrite,
        StAdvance
    } state_t;

    localparam int unsigned SYNC_LEN_DEFAULT = 10;

endpackage

// File: rtl/iecdrv_track_stream_if.sv
// Byte port between the head streamer and the track buffer (iecdrv_mem timing).
interface iecdrv_track_stream_if #(
    parameter int unsigned ADDRWIDTH = 13
);

    logic [ADDRWIDTH-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 mem_wren;
    logic [7:0]           mem_q;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wren,
        input  mem_q
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wren,
        output mem_q
    );

endinterface

// File: rtl/iecdrv_bit_timer.sv
// Bit-cell divider: counts ce pulses while the motor runs, ticks every bit_div+1 pulses.
module iecdrv_bit_timer #(
    parameter int unsigned DIVWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                mtr,
    input  logic [DIVWIDTH-1:0] bit_div,
    output logic                tick
);

    logic [DIVWIDTH-1:0] timer_q;
    logic [DIVWIDTH-1:0] timer_d;

    // A bit_div lowered below the running count reloads at once instead of wrapping.
    always_comb begin
        timer_d = timer_q;
        tick    = 1'b0;
        if (ce && mtr) begin
            if (timer_q >= bit_div) begin
                timer_d = '0;
                tick    = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/iecdrv_track_stream.sv
// Head-side streamer: serialises track-buffer bytes MSB first onto the head bit port
// and writes back bytes assembled from the write head.
module iecdrv_track_stream
    import iecdrv_track_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 13,
    parameter int unsigned DIVWIDTH  = 8,
    parameter int unsigned SYNC_LEN  = SYNC_LEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  mtr,
    input  logic                  wr_mode,
    input  logic [DIVWIDTH-1:0]   bit_div,
    input  logic [ADDRWIDTH-1:0]  track_len,
    input  logic                  din,
    output logic                  dout,
    output logic                  bit_strobe,
    output logic                  sync,
    output logic [ADDRWIDTH-1:0]  byte_pos,
    iecdrv_track_stream_if.master mem
);

    localparam int unsigned      CntW    = $clog2(SYNC_LEN + 1);
    localparam logic [CntW-1:0]  SyncMax = CntW'(SYNC_LEN);
    localparam logic [ADDRWIDTH:0] FullLen = {1'b1, {ADDRWIDTH{1'b0}}};

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           sr_q;
    logic [7:0]           sr_d;
    logic [2:0]           bit_cnt_q;
    logic [2:0]           bit_cnt_d;
    logic                 dirty_q;
    logic                 dirty_d;
    logic                 dout_q;
    logic                 dout_d;
    logic                 strobe_q;
    logic [CntW-1:0]      sync_cnt_q;
    logic [CntW-1:0]      sync_cnt_d;
    logic [ADDRWIDTH-1:0] byte_pos_q;
    logic [ADDRWIDTH-1:0] byte_pos_d;

    logic                 tick;
    logic                 strobe;
    logic [ADDRWIDTH:0]   eff_len;
    logic [ADDRWIDTH:0]   pos_next;
    logic                 pos_wrap;

    iecdrv_bit_timer #(
        .DIVWIDTH(DIVWIDTH)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .mtr    (mtr),
        .bit_div(bit_div),
        .tick   (tick)
    );

    // The timer free-runs through the byte turnaround; a cell is long enough that
    // its tick always lands back in SHIFT.
    assign strobe = tick && (state_q == StShift);

    assign eff_len  = (track_len == '0) ? FullLen : {1'b0, track_len};
    assign pos_next = {1'b0, byte_pos_q} + 1'b1;
    assign pos_wrap = (pos_next >= eff_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:   state_d = StWait1;
            StWait1:   state_d = StWait2;
            StWait2:   state_d = StShift;
            StShift: begin
                // A write on bit 7 itself must still trigger the write-back.
                if (strobe && (bit_cnt_q == 3'd7)) begin
                    state_d = (dirty_q || wr_mode) ? StWrite : StAdvance;
                end
            end
            StWrite:   state_d = StAdvance;
            StAdvance: state_d = StFetch;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        mem.mem_addr  = byte_pos_q;
        mem.mem_wren  = (state_q == StWrite);
        mem.mem_wdata = (state_q == StWrite) ? sr_q : 8'h00;
    end

    always_comb begin
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        dirty_d    = dirty_q;
        dout_d     = dout_q;
        sync_cnt_d = sync_cnt_q;
        byte_pos_d = byte_pos_q;

        if (state_q == StWait2) begin
            sr_d    = mem.mem_q;
            dirty_d = 1'b0;
        end

        if (strobe) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (wr_mode) begin
                dout_d     = din;
                sr_d       = {sr_q[6:0], din};
                dirty_d    = 1'b1;
                sync_cnt_d = '0;
            end else begin
                // Rotating keeps the byte intact so a partly written byte writes back whole.
                dout_d = sr_q[7];
                sr_d   = {sr_q[6:0], sr_q[7]};
                if (!sr_q[7]) begin
                    sync_cnt_d = '0;
                end else if (sync_cnt_q < SyncMax) begin
                    sync_cnt_d = sync_cnt_q + 1'b1;
                end
            end
        end

        if (state_q == StAdvance) begin
            byte_pos_d = pos_wrap ? '0 : pos_next[ADDRWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            dirty_q    <= 1'b0;
            dout_q     <= 1'b0;
            strobe_q   <= 1'b0;
            sync_cnt_q <= '0;
            byte_pos_q <= '0;
        end else begin
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            dirty_q    <= dirty_d;
            dout_q     <= dout_d;
            strobe_q   <= strobe;
            sync_cnt_q <= sync_cnt_d;
            byte_pos_q <= byte_pos_d;
        end
    end

    assign dout       = dout_q;
    assign bit_strobe = strobe_q;
    assign sync       = (sync_cnt_q >= SyncMax);
    assign byte_pos   = byte_pos_q;

endmodule

// File: tb/tb_iecdrv_track_stream.sv
// Directed bench for iecdrv_track_stream: a track-level model checks every cycle,
// literal expectations pin the model.
module tb_iecdrv_track_stream;

    localparam int unsigned AW   = 13;
    localparam int unsigned DW   = 8;
    localparam int          SLEN = 10;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          ce        = 1'b1;
    logic          mtr       = 1'b1;
    logic          wr_mode   = 1'b0;
    logic          din       = 1'b0;
    logic [DW-1:0] bit_div   = 8'd7;
    logic [AW-1:0] track_len = 13'd2;
    logic          dout;
    logic          bit_strobe;
    logic          sync;
    logic [AW-1:0] byte_pos;

    iecdrv_track_stream_if #(.ADDRWIDTH(AW)) mem_if ();

    iecdrv_track_stream #(
        .ADDRWIDTH(AW),
        .DIVWIDTH (DW),
        .SYNC_LEN (SLEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .mtr       (mtr),
        .wr_mode   (wr_mode),
        .bit_div   (bit_div),
        .track_len (track_len),
        .din       (din),
        .dout      (dout),
        .bit_strobe(bit_strobe),
        .sync      (sync),
        .byte_pos  (byte_pos),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    // Track buffer with iecdrv_mem timing: q valid two clocks after the address.
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_addr_q;
    logic          ld_req = 1'b0;
    logic [7:0]    init_track [0:7];

    always @(posedge clk) begin
        if (ld_req) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_track[i];
        end else if (mem_if.mem_wren) begin
            mem[mem_if.mem_addr] <= mem_if.mem_wdata;
        end
        rd_addr_q    <= mem_if.mem_addr;
        mem_if.mem_q <= mem[rd_addr_q];
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    int   nstb     = 0;
    logic ce_alt   = 1'b0;

    // Track-level model state.
    logic [7:0] ref_track [0:7];
    int         m_pos, m_bit, m_pulses, m_run, wren_cnt, pend_addr;
    logic       m_dirty, m_dout, pend;
    logic [7:0] m_asm, pend_data;
    logic       dout_log [$];
    logic       sync_log [$];
    logic       prev_reset = 1'b1, prev_ce, prev_mtr, prev_wr, prev_din;
    logic [DW-1:0] prev_div;
    logic [AW-1:0] prev_len;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int eff_len(input logic [AW-1:0] len);
        return (len == '0) ? (1 << AW) : int'(len);
    endfunction

    function automatic int log_byte(input int s);
        int v = 0;
        for (int i = 0; i < 8; i++) begin
            v = v << 1;
            if (s + i < dout_log.size()) v = v | int'(dout_log[s + i]);
        end
        return v;
    endfunction

    task automatic compare_cycle();
        logic exp_stb;
        logic b;
        if (ld_req) for (int i = 0; i < 8; i++) ref_track[i] = init_track[i];
        if (reset) begin
            m_pos = 0; m_bit = 0; m_pulses = 0; m_run = 0; m_dirty = 0; m_asm = 0;
            m_dout = 0; pend = 0; wren_cnt = 0;
            dout_log.delete(); sync_log.delete();
            check("rst_dout", dout, 0);
            check("rst_strobe", bit_strobe, 0);
            check("rst_sync", sync, 0);
            check("rst_byte_pos", byte_pos, 0);
            check("rst_mem_addr", mem_if.mem_addr, 0);
            check("rst_mem_wdata", mem_if.mem_wdata, 0);
            check("rst_mem_wren", mem_if.mem_wren, 0);
        end else if (!prev_reset) begin
            exp_stb = 1'b0;
            if (prev_ce && prev_mtr) begin
                m_pulses++;
                if (m_pulses == int'(prev_div) + 1) begin
                    exp_stb  = 1'b1;
                    m_pulses = 0;
                end
            end
            check("bit_strobe", bit_strobe, exp_stb);
            if (exp_stb) begin
                check("write_before_next_bit", pend, 0);
                check("byte_pos", byte_pos, m_pos);
                if (prev_wr) begin
                    b = prev_din; m_dirty = 1; m_run = 0;
                end else begin
                    b = ref_track[m_pos][7 - m_bit];
                    m_run = b ? ((m_run < SLEN) ? m_run + 1 : SLEN) : 0;
                end
                m_dout = b;
                m_asm[7 - m_bit] = b;
                dout_log.push_back(b);
                sync_log.push_back(m_run >= SLEN);
                m_bit++;
                if (m_bit == 8) begin
                    if (m_dirty) begin
                        pend = 1; pend_addr = m_pos; pend_data = m_asm;
                    end
                    m_bit = 0; m_dirty = 0;
                    m_pos = (m_pos + 1 >= eff_len(prev_len)) ? 0 : m_pos + 1;
                end
            end
            check("dout", dout, m_dout);
            check("sync", sync, m_run >= SLEN);
            if (mem_if.mem_wren) begin
                wren_cnt++;
                check("wren_expected", pend, 1);
                check("wr_addr", mem_if.mem_addr, pend_addr);
                check("wr_data", mem_if.mem_wdata, pend_data);
                if (pend) ref_track[pend_addr] = pend_data;
                pend = 0;
            end
        end
        prev_reset = reset; prev_ce = ce; prev_mtr = mtr; prev_wr = wr_mode;
        prev_din = din; prev_div = bit_div; prev_len = track_len;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ce_alt) ce = ~ce;
        if (bit_strobe) nstb++;
    endtask

    task automatic wait_strobes(input int n, output int cyc);
        int target = nstb + n;
        cyc = 0;
        while (nstb < target && cyc < n * 100 + 100) begin
            step();
            cyc++;
        end
        check("strobe_wait", nstb, target);
    endtask

    task automatic wait_until(input int k);
        int cyc;
        wait_strobes(k - nstb, cyc);
    endtask

    task automatic start_test(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [AW-1:0] len,
                              input logic [DW-1:0] div, input logic alt);
        reset = 1; wr_mode = 0; din = 0; mtr = 1; ce = 1; ce_alt = 0;
        bit_div = div; track_len = len;
        init_track[0] = b0; init_track[1] = b1; init_track[2] = b2; init_track[3] = b3;
        for (int i = 4; i < 8; i++) init_track[i] = 8'h00;
        ld_req = 1; step(); step(); ld_req = 0; step();
        reset = 0; ce_alt = alt; nstb = 0;
    endtask

    task automatic write_bits(input logic [7:0] b, input int n);
        int cyc;
        wr_mode = 1;
        for (int i = 0; i < n; i++) begin
            din = b[7 - i];
            wait_strobes(1, cyc);
        end
        wr_mode = 0;
        din = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int seen;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Plain read stream, two-byte track.
        start_test(8'hA5, 8'h3C, 8'h00, 8'h00, 13'd2, 8'd7, 1'b0);
        wait_until(9);
        check("t1_pos_byte1", byte_pos, 1);
        wait_until(17);
        check("t1_pos_wrapped", byte_pos, 0);
        wait_until(20);
        wait_strobes(1, cyc);
        check("t1_cell_clocks", cyc, 8);
        wait_until(32);
        check("t1_rev1_b0", log_byte(0), 'hA5);
        check("t1_rev1_b1", log_byte(8), 'h3C);
        check("t1_rev2_b0", log_byte(16), 'hA5);
        check("t1_rev2_b1", log_byte(24), 'h3C);

        // Sync detection, ce at half rate.
        start_test(8'hFF, 8'hC0, 8'h00, 8'h00, 13'd2, 8'd3, 1'b1);
        wait_until(12);
        check("t2_sync_9th_one", sync_log[8], 0);
        check("t2_sync_10th_one", sync_log[9], 1);
        check("t2_sync_after_zero", sync_log[10], 0);

        // Full-byte write at byte 3, reread, then shrink the track under the head.
        start_test(8'h11, 8'h22, 8'h33, 8'h44, 13'd4, 8'd7, 1'b0);
        wait_until(24);
        write_bits(8'h52, 8);
        wait_until(33);
        check("t3_wren_count", wren_cnt, 1);
        check("t3_mem3", mem[3], 'h52);
        wait_until(64);
        check("t3_reread", log_byte(56), 'h52);
        check("t3_wren_once", wren_cnt, 1);
        wait_until(81);
        track_len = 13'd1;
        wait_until(89);
        check("t3_shrink_wrap", byte_pos, 0);
        wait_until(97);
        check("t3_len1_stays", byte_pos, 0);

        // Partial write of bits 0..3 after a sync run.
        start_test(8'hFF, 8'hFF, 8'h00, 8'h00, 13'd3, 8'd7, 1'b0);
        wait_until(16);
        check("t4_sync_before", sync, 1);
        wr_mode = 1; din = 1;
        wait_strobes(1, cyc);
        check("t4_sync_cleared", sync, 0);
        wait_strobes(3, cyc);
        wr_mode = 0; din = 0;
        wait_until(25);
        check("t4_mem2", mem[2], 'hF0);
        wait_until(48);
        check("t4_reread", log_byte(40), 'hF0);

        // Motor stop after bit 4.
        start_test(8'hA5, 8'h3C, 8'h00, 8'h00, 13'd2, 8'd7, 1'b0);
        wait_until(5);
        mtr = 0;
        seen = nstb;
        for (int i = 0; i < 100; i++) step();
        check("t5_no_strobes", nstb - seen, 0);
        check("t5_pos_held", byte_pos, 0);
        check("t5_dout_held", dout, 0);
        mtr = 1;
        wait_strobes(1, cyc);
        check("t5_resume_bit5", dout, 1);

        // Single-byte track: write then immediate reread of address 0.
        start_test(8'h00, 8'h00, 8'h00, 8'h00, 13'd1, 8'd7, 1'b0);
        write_bits(8'h5A, 8);
        wait_until(16);
        check("t6_len1_reread", log_byte(8), 'h5A);

        // Reset while the write-back is on the bus.
        start_test(8'h12, 8'h34, 8'h00, 8'h00, 13'd2, 8'd7, 1'b0);
        write_bits(8'hEE, 8);
        for (int i = 0; i < 20 && !mem_if.mem_wren; i++) step();
        check("t7_wren_seen", mem_if.mem_wren, 1);
        #2 reset = 1;
        #1;
        check("t7_rst_wren", mem_if.mem_wren, 0);
        check("t7_rst_wdata", mem_if.mem_wdata, 0);
        check("t7_rst_addr", mem_if.mem_addr, 0);
        check("t7_rst_dout", dout, 0);
        check("t7_rst_sync", sync, 0);
        step(); step(); step();
        reset = 0; nstb = 0;
        check("t7_first_fetch_addr", mem_if.mem_addr, 0);
        wait_until(8);
        check("t7_write_dropped", log_byte(0), 'h12);
        check("t7_mem0_unchanged", mem[0], 'h12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
